// File: rtl/instr_buffer_pkg.sv
// Shared configuration, payload type and helpers for the instruction buffer.
// core_config holds sizing defaults, core_types the entry struct.
package core_config;
    localparam int CFG_FETCH_WIDTH  = 4;
    localparam int CFG_DECODE_WIDTH = 2;
    localparam int CFG_IB_DEPTH     = 16;
endpackage

package core_types;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        excp;
        logic [5:0]  excp_num;
        logic [3:0]  ftq_id;
        logic        is_last_in_block;
    } instr_buffer_info_t;
endpackage

package instr_buffer_pkg;
    import core_types::*;

    // Stored entries carry whatever valid bit arrived; presentation forces it.
    function automatic instr_buffer_info_t ib_present(instr_buffer_info_t e);
        instr_buffer_info_t r;
        r       = e;
        r.valid = 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/instr_buffer.sv
// Instruction buffer: circular FIFO between IFU fetch lanes and decode ports.
// Ports: clk, rst_n (async, active-low), flush_i, frontend_instr_i[FETCH_WIDTH],
//   frontend_stallreq_o, backend_instr_o[DECODE_WIDTH], backend_accept_i.
//   With IB_PERF_CNT_EN defined: stall_cycles_o (saturating stall counter).
module instr_buffer
    import core_config::*;
    import core_types::*;
    import instr_buffer_pkg::*;
#(
    parameter int FETCH_WIDTH  = CFG_FETCH_WIDTH,
    parameter int DECODE_WIDTH = CFG_DECODE_WIDTH,
    parameter int IB_DEPTH     = CFG_IB_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef IB_PERF_CNT_EN
    output logic [31:0]             stall_cycles_o,
`endif
    input  logic                    flush_i,
    input  instr_buffer_info_t      frontend_instr_i [FETCH_WIDTH],
    output logic                    frontend_stallreq_o,
    output instr_buffer_info_t      backend_instr_o [DECODE_WIDTH],
    input  logic [DECODE_WIDTH-1:0] backend_accept_i
);

    localparam int PW = $clog2(IB_DEPTH);
    localparam int CW = $clog2(IB_DEPTH + 1);

    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count;
    logic [CW-1:0]      n_wr;
    logic [CW-1:0]      n_rd;
    logic               wr_en;
    instr_buffer_info_t mem [IB_DEPTH];

    // Depends on registered count only, so reset forces it low.
    assign frontend_stallreq_o =
        (CW'(IB_DEPTH) - count) < CW'(FETCH_WIDTH);

    assign wr_en = !frontend_stallreq_o && !flush_i;

    // Valid lanes are contiguous from lane 0, so a popcount is the write size.
    always_comb begin
        n_wr = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (frontend_instr_i[i].valid) begin
                n_wr = n_wr + CW'(1);
            end
        end
    end

    // Accepts on ports beyond count are ignored.
    always_comb begin
        n_rd = '0;
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            if (backend_accept_i[k] && (CW'(k) < count)) begin
                n_rd = n_rd + CW'(1);
            end
        end
    end

    always_comb begin
        logic [PW-1:0] rd_idx;
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            rd_idx             = head + PW'(k);
            backend_instr_o[k] = '0;
            if (CW'(k) < count) begin
                backend_instr_o[k] = ib_present(mem[rd_idx]);
            end
        end
    end

    // Storage needs no reset: visibility is governed by count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (frontend_instr_i[i].valid) begin
                    mem[tail + PW'(i)] <= frontend_instr_i[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_rd);
            if (wr_en) begin
                tail <= tail + PW'(n_wr);
            end
            count <= count + (wr_en ? n_wr : CW'(0)) - n_rd;
        end
    end

`ifdef IB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_o <= '0;
        end else if (frontend_stallreq_o && (stall_cycles_o != '1)) begin
            stall_cycles_o <= stall_cycles_o + 32'd1;
        end
    end
`endif

endmodule
